// File: rtl/alu_issue_decoder.sv
// RV64I integer-ALU decode/issue stage with a main entry plus one skid entry.
// Define ALU_ISSUE_DECODER_STATS_EN to build the decoded/illegal instruction counters.
package def_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic {ALU_OP_64 = 1'b0, ALU_OP_32 = 1'b1} alu_width_t;

  typedef struct packed {
    alu_op_t    alu_op;
    alu_width_t alu_width;
  } alu_control_packet_t;

  typedef struct packed {
    alu_control_packet_t ctrl;
    logic [63:0]         op1;
    logic [63:0]         op2;
    logic [4:0]          rd;
    logic                rd_we;
    logic                illegal;
  } issue_pkt_t;
endpackage

module alu_issue_decoder
  import def_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                out_valid,
  input  logic                out_ready,
  output alu_control_packet_t out_alu_control,
  output logic [XLEN-1:0]     out_operand_1,
  output logic [XLEN-1:0]     out_operand_2,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic                out_illegal,
  output logic [31:0]         stat_decoded,
  output logic [31:0]         stat_illegal
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_i;
  logic [63:0] imm_u;
  logic        legal;
  alu_op_t     dec_op;
  alu_width_t  dec_width;
  logic [63:0] dec_op1;
  logic [63:0] dec_op2;
  issue_pkt_t  dec_pkt;
  issue_pkt_t  main_pkt;
  issue_pkt_t  skid_pkt;
  logic        main_valid;
  logic        skid_valid;
  logic        accept;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{52{in_inst[31]}}, in_inst[31:20]};
  assign imm_u  = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};

  always_comb begin
    legal     = 1'b1;
    dec_op    = ALU_ADD;
    dec_width = ALU_OP_64;
    dec_op1   = rs1_data;
    dec_op2   = rs2_data;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: dec_op = ALU_ADD;
            3'd1: dec_op = ALU_SLL;
            3'd2: dec_op = ALU_SLT;
            3'd3: dec_op = ALU_SLTU;
            3'd4: dec_op = ALU_XOR;
            3'd5: dec_op = ALU_SRL;
            3'd6: dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) dec_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'd5) dec_op = ALU_SRA;
        else legal = 1'b0;
      end
      OPC_OP_32: begin
        dec_width = ALU_OP_32;
        if (funct7 == 7'h00 && funct3 == 3'd0) dec_op = ALU_ADD;
        else if (funct7 == 7'h00 && funct3 == 3'd1) dec_op = ALU_SLL;
        else if (funct7 == 7'h00 && funct3 == 3'd5) dec_op = ALU_SRL;
        else if (funct7 == 7'h20 && funct3 == 3'd0) dec_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'd5) dec_op = ALU_SRA;
        else legal = 1'b0;
      end
      OPC_OP_IMM: begin
        dec_op2 = imm_i;
        case (funct3)
          3'd0: dec_op = ALU_ADD;
          3'd2: dec_op = ALU_SLT;
          3'd3: dec_op = ALU_SLTU;
          3'd4: dec_op = ALU_XOR;
          3'd6: dec_op = ALU_OR;
          3'd7: dec_op = ALU_AND;
          default: begin
            // 64-bit shifts: bit 25 belongs to shamt, so only inst[31:26] qualifies the op
            dec_op2 = {58'd0, in_inst[25:20]};
            if (in_inst[31:26] == 6'b000000) dec_op = (funct3 == 3'd1) ? ALU_SLL : ALU_SRL;
            else if (in_inst[31:26] == 6'b010000 && funct3 == 3'd5) dec_op = ALU_SRA;
            else legal = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        dec_width = ALU_OP_32;
        dec_op2   = imm_i;
        if (funct3 == 3'd0) dec_op = ALU_ADD;
        else if (funct3 == 3'd1 || funct3 == 3'd5) begin
          dec_op2 = {59'd0, in_inst[24:20]};
          if (funct7 == 7'h00) dec_op = (funct3 == 3'd1) ? ALU_SLL : ALU_SRL;
          else if (funct7 == 7'h20 && funct3 == 3'd5) dec_op = ALU_SRA;
          else legal = 1'b0;
        end else legal = 1'b0;
      end
      OPC_LUI: begin
        dec_op1 = '0;
        dec_op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_op1 = in_pc;
        dec_op2 = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_pkt                = '0;
    dec_pkt.rd             = in_inst[11:7];
    dec_pkt.illegal        = !legal;
    dec_pkt.ctrl.alu_op    = ALU_ADD;
    dec_pkt.ctrl.alu_width = ALU_OP_64;
    if (legal) begin
      dec_pkt.ctrl.alu_op    = dec_op;
      dec_pkt.ctrl.alu_width = dec_width;
      dec_pkt.op1            = dec_op1;
      dec_pkt.op2            = dec_op2;
      dec_pkt.rd_we          = (in_inst[11:7] != 5'd0);
    end
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  // Skid only fills while main is held, so an empty main implies an empty skid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pkt   <= '0;
      skid_pkt   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_pkt   <= skid_pkt;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_pkt <= dec_pkt;
      end
    end else if (accept) begin
      skid_pkt   <= dec_pkt;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid       = main_valid;
  assign out_alu_control = main_pkt.ctrl;
  assign out_operand_1   = main_pkt.op1;
  assign out_operand_2   = main_pkt.op2;
  assign out_rd          = main_pkt.rd;
  assign out_rd_we       = main_pkt.rd_we;
  assign out_illegal     = main_pkt.illegal;

`ifdef ALU_ISSUE_DECODER_STATS_EN
  logic [31:0] decoded_cnt;
  logic [31:0] illegal_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (accept && !flush) begin
      decoded_cnt <= decoded_cnt + 32'd1;
      if (dec_pkt.illegal) illegal_cnt <= illegal_cnt + 32'd1;
    end
  end

  assign stat_decoded = decoded_cnt;
  assign stat_illegal = illegal_cnt;
`else
  assign stat_decoded = '0;
  assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: directed test-plan cases plus random traffic
// scored against a mask/match instruction-table model and an in-order packet queue.
module tb_alu_issue_decoder;
  import def_pkg::*;

  localparam int K_R = 0, K_I = 1, K_SH6 = 2, K_SH5 = 3, K_LUI = 4, K_AUIPC = 5;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    alu_op_t     op;
    logic        w32;
    int          kind;
  } tbl_t;

  typedef struct {
    alu_op_t     op;
    logic        w32;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  alu_control_packet_t out_alu_control;
  logic [63:0] out_operand_1;
  logic [63:0] out_operand_2;
  logic [4:0] out_rd;
  logic out_rd_we;
  logic out_illegal;
  logic [31:0] stat_decoded;
  logic [31:0] stat_illegal;

  int checks = 0;
  int failures = 0;
  tbl_t tbl[$];
  exp_t pending[$];
  int exp_decoded = 0;
  int exp_illegal = 0;

  alu_issue_decoder #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic addEntry(input logic [31:0] mask, input logic [31:0] match, input alu_op_t op,
                          input logic w32, input int kind);
    tbl_t e;
    e.mask = mask; e.match = match; e.op = op; e.w32 = w32; e.kind = kind;
    tbl.push_back(e);
  endtask

  // Reference decode: RISC-V mask/match lookup, then operands by instruction format
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc,
                                 input logic [63:0] r1, input logic [63:0] r2);
    exp_t e;
    longint v;
    int hit = -1;
    e.op = ALU_ADD; e.w32 = 1'b0; e.op1 = '0; e.op2 = '0;
    e.rd = inst[11:7]; e.rd_we = 1'b0; e.illegal = 1'b1;
    foreach (tbl[i]) if ((inst & tbl[i].mask) == tbl[i].match) hit = i;
    if (hit < 0) return e;
    e.illegal = 1'b0;
    e.op = tbl[hit].op;
    e.w32 = tbl[hit].w32;
    e.rd_we = (inst[11:7] != 0);
    e.op1 = r1;
    case (tbl[hit].kind)
      K_R: e.op2 = r2;
      K_I: begin
        v = longint'(inst[31:20]);
        if (v > 2047) v = v - 4096;
        e.op2 = 64'(v);
      end
      K_SH6: e.op2 = 64'(inst[25:20]);
      K_SH5: e.op2 = 64'(inst[24:20]);
      default: begin
        v = longint'(inst[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
        e.op2 = 64'(v);
        e.op1 = (tbl[hit].kind == K_AUIPC) ? pc : 64'd0;
      end
    endcase
    return e;
  endfunction

  // Called mid-cycle: score the outputs held since the last edge, then book this cycle's transfers
  task automatic observeCycle();
    if (rst_n) begin
      checkOutput("out_valid", 64'(out_valid), 64'(pending.size() > 0));
      checkOutput("in_ready", 64'(in_ready), 64'(pending.size() < 2));
      if (out_valid && pending.size() > 0) begin
        checkOutput("alu_op", 64'(out_alu_control.alu_op), 64'(pending[0].op));
        checkOutput("alu_width", 64'(out_alu_control.alu_width), 64'(pending[0].w32));
        checkOutput("operand_1", out_operand_1, pending[0].op1);
        checkOutput("operand_2", out_operand_2, pending[0].op2);
        checkOutput("rd", 64'(out_rd), 64'(pending[0].rd));
        checkOutput("rd_we", 64'(out_rd_we), 64'(pending[0].rd_we));
        checkOutput("illegal", 64'(out_illegal), 64'(pending[0].illegal));
      end
`ifdef ALU_ISSUE_DECODER_STATS_EN
      checkOutput("stat_decoded", 64'(stat_decoded), 64'(32'(exp_decoded)));
      checkOutput("stat_illegal", 64'(stat_illegal), 64'(32'(exp_illegal)));
`else
      checkOutput("stat_decoded_tied", 64'(stat_decoded), 64'd0);
      checkOutput("stat_illegal_tied", 64'(stat_illegal), 64'd0);
`endif
    end
    if (!rst_n) begin
      pending.delete();
      exp_decoded = 0;
      exp_illegal = 0;
    end else if (flush) begin
      pending.delete();
    end else begin
      if (out_valid && out_ready && pending.size() > 0) void'(pending.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(in_inst, in_pc, rs1_data, rs2_data);
        pending.push_back(e);
        exp_decoded++;
        if (e.illegal) exp_illegal++;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] inst,
                               input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                               input logic rdy, input logic fl);
    @(negedge clk);
    rst_n = rst; in_valid = vld; in_inst = inst; in_pc = pc;
    rs1_data = r1; rs2_data = r2; out_ready = rdy; flush = fl;
    #1;
    observeCycle();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0, 64'h0, 64'h0, rdy, 1'b0);
  endtask

  initial begin
    logic [6:0] opcodes [8];
    logic [31:0] inst;
    int idx;

    addEntry(32'hFE00707F, 32'h00000033, ALU_ADD, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h40000033, ALU_SUB, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00001033, ALU_SLL, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00002033, ALU_SLT, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00003033, ALU_SLTU, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00004033, ALU_XOR, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00005033, ALU_SRL, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h40005033, ALU_SRA, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00006033, ALU_OR, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h00007033, ALU_AND, 1'b0, K_R);
    addEntry(32'hFE00707F, 32'h0000003B, ALU_ADD, 1'b1, K_R);
    addEntry(32'hFE00707F, 32'h4000003B, ALU_SUB, 1'b1, K_R);
    addEntry(32'hFE00707F, 32'h0000103B, ALU_SLL, 1'b1, K_R);
    addEntry(32'hFE00707F, 32'h0000503B, ALU_SRL, 1'b1, K_R);
    addEntry(32'hFE00707F, 32'h4000503B, ALU_SRA, 1'b1, K_R);
    addEntry(32'h0000707F, 32'h00000013, ALU_ADD, 1'b0, K_I);
    addEntry(32'h0000707F, 32'h00002013, ALU_SLT, 1'b0, K_I);
    addEntry(32'h0000707F, 32'h00003013, ALU_SLTU, 1'b0, K_I);
    addEntry(32'h0000707F, 32'h00004013, ALU_XOR, 1'b0, K_I);
    addEntry(32'h0000707F, 32'h00006013, ALU_OR, 1'b0, K_I);
    addEntry(32'h0000707F, 32'h00007013, ALU_AND, 1'b0, K_I);
    addEntry(32'hFC00707F, 32'h00001013, ALU_SLL, 1'b0, K_SH6);
    addEntry(32'hFC00707F, 32'h00005013, ALU_SRL, 1'b0, K_SH6);
    addEntry(32'hFC00707F, 32'h40005013, ALU_SRA, 1'b0, K_SH6);
    addEntry(32'h0000707F, 32'h0000001B, ALU_ADD, 1'b1, K_I);
    addEntry(32'hFE00707F, 32'h0000101B, ALU_SLL, 1'b1, K_SH5);
    addEntry(32'hFE00707F, 32'h0000501B, ALU_SRL, 1'b1, K_SH5);
    addEntry(32'hFE00707F, 32'h4000501B, ALU_SRA, 1'b1, K_SH5);
    addEntry(32'h0000007F, 32'h00000037, ALU_ADD, 1'b0, K_LUI);
    addEntry(32'h0000007F, 32'h00000017, ALU_ADD, 1'b0, K_AUIPC);
    opcodes[0] = 7'h33; opcodes[1] = 7'h3B; opcodes[2] = 7'h13; opcodes[3] = 7'h1B;
    opcodes[4] = 7'h37; opcodes[5] = 7'h17; opcodes[6] = 7'h03; opcodes[7] = 7'h6F;

    applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_operand_1", out_operand_1, 64'd0);
    checkOutput("reset_operand_2", out_operand_2, 64'd0);
    checkOutput("reset_ctrl", 64'(out_alu_control), 64'd0);

    applyStimulus(1'b1, 1'b1, 32'hFFF08293, 64'h0, 64'd5, 64'd9, 1'b1, 1'b0);
    idle(1'b1);
    checkOutput("addi_valid", 64'(out_valid), 64'd1);
    checkOutput("addi_op", 64'(out_alu_control.alu_op), 64'(ALU_ADD));
    checkOutput("addi_op1", out_operand_1, 64'd5);
    checkOutput("addi_op2", out_operand_2, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_rd", 64'(out_rd), 64'd5);
    checkOutput("addi_rd_we", 64'(out_rd_we), 64'd1);

    applyStimulus(1'b1, 1'b1, 32'h123453B7, 64'h1000, 64'd7, 64'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h12345397, 64'h1000, 64'd7, 64'd7, 1'b1, 1'b0);
    checkOutput("lui_op1", out_operand_1, 64'd0);
    checkOutput("lui_op2", out_operand_2, 64'h0000_0000_1234_5000);
    idle(1'b1);
    checkOutput("auipc_op1", out_operand_1, 64'h1000);
    checkOutput("auipc_op2", out_operand_2, 64'h0000_0000_1234_5000);

    applyStimulus(1'b1, 1'b1, 32'h00100013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00200013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00300013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_a", out_operand_2, 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h00300013, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("bp_out_a", out_operand_2, 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h00300013, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("bp_out_b", out_operand_2, 64'd2);
    idle(1'b1);
    checkOutput("bp_out_c", out_operand_2, 64'd3);
    idle(1'b1);
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, 1'b1, 32'h00400013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00500013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00600013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);

    applyStimulus(1'b1, 1'b1, 32'h022081B3, 64'h0, 64'h11, 64'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0201109B, 64'h0, 64'h11, 64'h22, 1'b1, 1'b0);
    checkOutput("mul_illegal", 64'(out_illegal), 64'd1);
    checkOutput("mul_rd_we", 64'(out_rd_we), 64'd0);
    checkOutput("mul_op1", out_operand_1, 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h4031509B, 64'h0, 64'h11, 64'h22, 1'b1, 1'b0);
    checkOutput("slliw25_illegal", 64'(out_illegal), 64'd1);
    idle(1'b1);
    checkOutput("sraiw_op", 64'(out_alu_control.alu_op), 64'(ALU_SRA));
    checkOutput("sraiw_width", 64'(out_alu_control.alu_width), 64'(ALU_OP_32));
    checkOutput("sraiw_op2", out_operand_2, 64'd3);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 70) begin
        idx = $urandom_range(tbl.size() - 1);
        inst = ($urandom() & ~tbl[idx].mask) | tbl[idx].match;
      end else begin
        inst = $urandom();
        inst[6:0] = opcodes[$urandom_range(7)];
      end
      applyStimulus(($urandom_range(999) < 3) ? 1'b0 : 1'b1, ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                    inst, {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    ($urandom_range(99) < 60) ? 1'b1 : 1'b0, ($urandom_range(99) < 3) ? 1'b1 : 1'b0);
    end

    for (int n = 0; n < 20 && pending.size() > 0; n++) idle(1'b1);
    checkOutput("final_drain", 64'(pending.size()), 64'd0);

    applyStimulus(1'b1, 1'b1, 32'h00700013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00800013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h00900013, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_stat_decoded", 64'(stat_decoded), 64'd0);
    checkOutput("midreset_stat_illegal", 64'(stat_illegal), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
